pps_monitor: RTL



---
 rtl/pps_monitor_if.sv | 39 +++
 rtl/pps_monitor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pps_monitor_if.sv
// pps_monitor_if: groups the monitored PPS input and the measurement results.
//
// Signalling: there is no backpressure. o_valid is a one-cycle strobe that
// marks a fresh o_period; o_err is a one-cycle strobe that can only be high
// together with o_valid. o_locked and o_timeout are levels. o_state is a
// debug copy of the monitor FSM state (0=SEARCH, 1=TRACK, 2=LOCKED).
interface pps_monitor_if #(
    parameter int W = 9
);
    logic         i_pps;
    logic [W-1:0] o_period;
    logic         o_valid;
    logic         o_err;
    logic         o_locked;
    logic         o_timeout;
    logic [1:0]   o_state;

    // Monitor side: samples the PPS input and drives the results.
    modport master (
        input  i_pps,
        output o_period,
        output o_valid,
        output o_err,
        output o_locked,
        output o_timeout,
        output o_state
    );

    // Source/observer side: drives the PPS input and reads the results.
    modport slave (
        output i_pps,
        input  o_period,
        input  o_valid,
        input  o_err,
        input  o_locked,
        input  o_timeout,
        input  o_state
    );
endinterface

// File: rtl/pps_monitor.sv
// pps_monitor: measures the rise-to-rise period of a PPS-style square wave
// in i_clk ticks and declares lock after LOCK_COUNT consecutive periods
// within +/-TOLERANCE ticks of CLOCK_RATE_HZ.
//
// Build option PPS_MONITOR_SYNC_EN: when defined, a 2-flop synchronizer sits
// in front of the edge-detect history flop (needed for an asynchronous PPS).
// With it, o_valid rises on the 3rd edge counting the edge that first
// samples i_pps=1; without it, on that same edge. The measured period does
// not depend on the synchronizer depth.
module pps_monitor #(
    parameter int CLOCK_RATE_HZ = 100,
    parameter int TOLERANCE     = 2,
    parameter int LOCK_COUNT    = 3
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    pps_monitor_if.master bus
);
    localparam int W       = $clog2(2 * CLOCK_RATE_HZ) + 1;
    localparam int TIMEOUT = 2 * CLOCK_RATE_HZ;
    localparam int GW      = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

    localparam logic [W-1:0]  CNT_MAX   = W'(TIMEOUT - 1);
    localparam logic [W:0]    TOL_LO    = (W + 1)'((CLOCK_RATE_HZ > TOLERANCE) ?
                                                   (CLOCK_RATE_HZ - TOLERANCE) : 0);
    localparam logic [W:0]    TOL_HI    = (W + 1)'(CLOCK_RATE_HZ + TOLERANCE);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  cnt;
    logic [GW-1:0] good;
    logic          pps_cur;
    logic          pps_hist;
    logic          rise;
    logic [W:0]    period_w;
    logic          in_tol;
    logic          cnt_at_max;

`ifdef PPS_MONITOR_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for an i_pps that is asynchronous to i_clk.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.i_pps};
        end
    end

    assign pps_cur = sync_q[1];
`else
    assign pps_cur = bus.i_pps;
`endif

    // History flop for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pps_hist <= 1'b0;
        end else begin
            pps_hist <= pps_cur;
        end
    end

    assign rise       = pps_cur & ~pps_hist;
    assign cnt_at_max = (cnt == CNT_MAX);

    // Period ending at this rise; one extra bit so the tolerance compare never wraps.
    assign period_w = {1'b0, cnt} + (W + 1)'(1);
    assign in_tol   = (period_w >= TOL_LO) && (period_w <= TOL_HI);

    // Tick counter: restarts on each rise, holds at TIMEOUT-1 when no edge comes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (!cnt_at_max) begin
            cnt <= cnt + W'(1);
        end
    end

    // Monitor FSM with registered result outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= SEARCH;
            good          <= '0;
            bus.o_period  <= '0;
            bus.o_valid   <= 1'b0;
            bus.o_err     <= 1'b0;
            bus.o_locked  <= 1'b0;
            bus.o_timeout <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;
            bus.o_err   <= 1'b0;
            case (state)
                SEARCH: begin
                    // First edge only gives a reference point; nothing to measure yet.
                    if (rise) begin
                        state         <= TRACK;
                        good          <= '0;
                        bus.o_timeout <= 1'b0;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        bus.o_valid  <= 1'b1;
                        bus.o_period <= period_w[W-1:0];
                        if (in_tol) begin
                            if (good == GOOD_LAST) begin
                                state        <= LOCKED;
                                good         <= '0;
                                bus.o_locked <= 1'b1;
                            end else begin
                                good <= good + GW'(1);
                            end
                        end else begin
                            bus.o_err <= 1'b1;
                            good      <= '0;
                        end
                    end else if (cnt_at_max) begin
                        state         <= SEARCH;
                        good          <= '0;
                        bus.o_timeout <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        bus.o_valid  <= 1'b1;
                        bus.o_period <= period_w[W-1:0];
                        if (!in_tol) begin
                            bus.o_err    <= 1'b1;
                            bus.o_locked <= 1'b0;
                            state        <= TRACK;
                            good         <= '0;
                        end
                    end else if (cnt_at_max) begin
                        state         <= SEARCH;
                        good          <= '0;
                        bus.o_locked  <= 1'b0;
                        bus.o_timeout <= 1'b1;
                    end
                end
                default: begin
                    state        <= SEARCH;
                    good         <= '0;
                    bus.o_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_state = state;

endmodule
